inst_rom_arbiter: RTL

Two-requester arbiter that shares the single-port instruction ROM between the `openmips` fetch port (port 0) and a debug/loader read port (port 1). It sits between the CPU and `inst_rom` in the SOPC and drives the ROM's chip-enable and address. It also routes each read response back to the port that issued it. Issue is one beat per cycle with no bubble on owner switch, and ROM read latency is configurable.

---
 rtl/inst_rom_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/inst_rom_arbiter.sv
// rtl/inst_rom_arbiter.sv - two-port instruction ROM arbiter with in-order response routing
// Define ROM_ARB_RR_EN for round-robin with MAX_HOLD limit; default build is fixed priority (port 0 wins).
module inst_rom_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic [READ_LAT-1:0] r_tag_v;
  logic [READ_LAT-1:0] r_tag_p;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_issue;
`ifdef ROM_ARB_RR_EN
  logic                r_last;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

`ifdef ROM_ARB_RR_EN
  // Resets to 1 so that port 0 wins the first contest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_last <= 1'b1;
    else if (w_issue) r_last <= w_gnt1;
  end
`endif

  // Tag pipe: one {valid, port} entry per issued beat, tail lines up with rom_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_v <= '0;
      r_tag_p <= '0;
    end else begin
      r_tag_v[0] <= w_issue;
      r_tag_p[0] <= w_gnt1;
      for (int i = 1; i < READ_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_p[i] <= r_tag_p[i-1];
      end
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_hold_nxt  = '0;
    if (w_issue) begin
      w_state_nxt = w_gnt1 ? OWN1 : OWN0;
      if (r_state == w_state_nxt)
        w_hold_nxt = (r_hold_cnt < HOLD_MAX) ? r_hold_cnt + HOLD_W'(1) : r_hold_cnt;
      else
        w_hold_nxt = HOLD_W'(1);
    end
  end

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst) begin
`ifdef ROM_ARB_RR_EN
      if (m0_req && m1_req) begin
        if (r_state == OWN0 && r_hold_cnt < HOLD_MAX)      w_gnt0 = 1'b1;
        else if (r_state == OWN1 && r_hold_cnt < HOLD_MAX) w_gnt1 = 1'b1;
        else if (r_last)                                   w_gnt0 = 1'b1;
        else                                               w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
`else
      w_gnt0 = m0_req;
      w_gnt1 = m1_req && !m0_req;
`endif
    end
    w_issue  = w_gnt0 | w_gnt1;
    m0_gnt   = w_gnt0;
    m1_gnt   = w_gnt1;
    rom_ce   = w_issue;
    rom_addr = w_gnt1 ? m1_addr : (w_gnt0 ? m0_addr : '0);
  end

  assign m0_rvalid = r_tag_v[READ_LAT-1] && !r_tag_p[READ_LAT-1];
  assign m1_rvalid = r_tag_v[READ_LAT-1] &&  r_tag_p[READ_LAT-1];
  assign m0_rdata  = rom_data;
  assign m1_rdata  = rom_data;

endmodule
